// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// A transfer happens in any cycle where imem_req_o and imem_ready_i are both high.
interface if_fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;

  modport master (output imem_req_o, imem_addr_o, input  imem_ready_i, imem_rdata_i);
  modport slave  (input  imem_req_o, imem_addr_o, output imem_ready_i, imem_rdata_i);
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem request, 1-entry skid buffer for
// downstream stalls, and a DISCARD state that drains a request squashed by a redirect.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  if_fetch_if.master  imem,
  output logic [31:0] nextPC_IF,
  output logic [31:0] RD_IF,
  output logic        valid_IF
);

  typedef enum logic [1:0] {RUN, FULL, DISCARD} state_t;

  typedef struct packed {
    logic        full;
    logic [31:0] instr;
    logic [31:0] npc;
  } skid_t;

  state_t      state, state_nxt;
  skid_t       skid, skid_nxt;
  logic [31:0] pc, pc_nxt, req_addr, req_addr_nxt;
  logic [31:0] rd_nxt, npc_nxt, tgt;
  logic        vld_nxt, req, xfer;

  assign tgt = redirect_pc_i & ~32'h3;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    rd_nxt       = RD_IF;
    npc_nxt      = nextPC_IF;
    vld_nxt      = valid_IF;
    skid_nxt     = skid;

    // FULL re-issues in the same cycle the stall drops, so the skid slot refills
    // while its contents move to the output registers.
    case (state)
      RUN, DISCARD: req = 1'b1;
      FULL:         req = ~stall_i & ~redirect_i;
      default:      req = 1'b0;
    endcase
    xfer = req & imem.imem_ready_i;

    if (redirect_i) begin
      pc_nxt   = tgt;
      skid_nxt = '0;
      rd_nxt   = '0;
      npc_nxt  = '0;
      vld_nxt  = 1'b0;
      // A pending, unaccepted request must stay on the bus until accepted.
      if (!req || xfer) begin
        req_addr_nxt = tgt;
        state_nxt    = RUN;
      end else begin
        state_nxt    = DISCARD;
      end
    end else begin
      case (state)
        RUN: begin
          if (xfer) begin
            pc_nxt       = pc + 32'd4;
            req_addr_nxt = req_addr + 32'd4;
            if (stall_i) begin
              skid_nxt  = '{full: 1'b1, instr: imem.imem_rdata_i, npc: req_addr + 32'd4};
              state_nxt = FULL;
            end else begin
              rd_nxt  = imem.imem_rdata_i;
              npc_nxt = req_addr + 32'd4;
              vld_nxt = 1'b1;
            end
          end else if (!stall_i) begin
            vld_nxt = 1'b0;
          end
        end
        FULL: begin
          if (!stall_i) begin
            rd_nxt  = skid.instr;
            npc_nxt = skid.npc;
            vld_nxt = skid.full;
            if (xfer) begin
              pc_nxt       = pc + 32'd4;
              req_addr_nxt = req_addr + 32'd4;
              skid_nxt     = '{full: 1'b1, instr: imem.imem_rdata_i, npc: req_addr + 32'd4};
            end else begin
              skid_nxt  = '0;
              state_nxt = RUN;
            end
          end
        end
        DISCARD: begin
          if (!stall_i) vld_nxt = 1'b0;
          if (xfer) begin
            req_addr_nxt = pc;
            state_nxt    = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end

    imem.imem_req_o  = req;
    imem.imem_addr_o = req_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      RD_IF     <= '0;
      nextPC_IF <= '0;
      valid_IF  <= 1'b0;
      skid      <= '0;
    end else begin
      pc        <= pc_nxt;
      req_addr  <= req_addr_nxt;
      RD_IF     <= rd_nxt;
      nextPC_IF <= npc_nxt;
      valid_IF  <= vld_nxt;
      skid      <= skid_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed cycle table for the corner cases, then random
// stall/redirect/ready traffic checked against an in-order instruction stream model.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        reset, stall_i, redirect_i;
  logic [31:0] redirect_pc_i, nextPC_IF, RD_IF;
  logic        valid_IF;
  int          tests = 0, fails = 0;

  if_fetch_if bus();

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign bus.imem_rdata_i = mem(bus.imem_addr_o);

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem(bus),
    .nextPC_IF(nextPC_IF), .RD_IF(RD_IF), .valid_IF(valid_IF)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_req, chk_addr;
    logic [31:0] exp_addr;
    logic        exp_vld;
    logic [31:0] exp_rd, exp_npc;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic rst, stall, redir, input logic [31:0] rpc,
                              input logic rdy, ereq, caddr, input logic [31:0] eaddr,
                              input logic evld, input logic [31:0] erd, enpc);
    vec_t v;
    v = '{rst, stall, redir, rpc, rdy, ereq, caddr, eaddr, evld, erd, enpc};
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; bus.imem_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", valid_IF, 0);
    chk("reset_rd",    RD_IF, 0);
    chk("reset_npc",   nextPC_IF, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_addr, prev_rd, prev_npc, pend_addr, rpc;
    logic        prev_vld, pend, st, rd_, rdy;
    int          presented;

    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; bus.imem_ready_i = 1'b0;

    // rst stall redir rpc rdy | req chk addr | vld rd npc
    add(0,0,0,0,1,             1,1,32'h0,          1,mem(32'h0),32'h4);
    add(0,0,0,0,1,             1,1,32'h4,          1,mem(32'h4),32'h8);
    add(0,0,0,0,1,             1,1,32'h8,          1,mem(32'h8),32'hC);
    add(0,0,0,0,1,             1,1,32'hC,          1,mem(32'hC),32'h10);
    add(0,1,0,0,1,             1,1,32'h10,         1,mem(32'hC),32'h10);
    add(0,1,0,0,1,             0,0,32'h0,          1,mem(32'hC),32'h10);
    add(0,1,0,0,1,             0,0,32'h0,          1,mem(32'hC),32'h10);
    add(0,0,0,0,1,             1,1,32'h14,         1,mem(32'h10),32'h14);
    add(0,0,0,0,0,             1,1,32'h18,         1,mem(32'h14),32'h18);
    add(0,0,0,0,0,             1,1,32'h18,         0,mem(32'h14),32'h18);
    add(0,0,0,0,1,             1,1,32'h18,         1,mem(32'h18),32'h1C);
    add(0,0,1,32'h40,0,        1,1,32'h1C,         0,0,0);
    add(0,0,0,0,0,             1,1,32'h1C,         0,0,0);
    add(0,0,0,0,1,             1,1,32'h1C,         0,0,0);
    add(0,0,0,0,1,             1,1,32'h40,         1,mem(32'h40),32'h44);
    add(0,1,1,32'h103,1,       1,1,32'h44,         0,0,0);
    add(0,0,0,0,0,             1,1,32'h100,        0,0,0);
    add(0,0,0,0,1,             1,1,32'h100,        1,mem(32'h100),32'h104);
    add(0,0,1,32'hFFFF_FFFE,0, 1,1,32'h104,        0,0,0);
    add(0,0,0,0,1,             1,1,32'h104,        0,0,0);
    add(0,0,0,0,1,             1,1,32'hFFFF_FFFC,  1,mem(32'hFFFF_FFFC),32'h0);
    add(0,0,0,0,1,             1,1,32'h0,          1,mem(32'h0),32'h4);
    add(0,0,1,32'h200,0,       1,1,32'h4,          0,0,0);
    add(0,0,1,32'h300,0,       1,1,32'h4,          0,0,0);
    add(0,0,0,0,1,             1,1,32'h4,          0,0,0);
    add(0,0,0,0,1,             1,1,32'h300,        1,mem(32'h300),32'h304);
    add(0,1,0,0,1,             1,1,32'h304,        1,mem(32'h300),32'h304);
    add(1,1,0,0,1,             0,0,32'h0,          0,0,0);
    add(0,0,0,0,0,             1,1,32'h0,          0,0,0);
    add(0,0,0,0,1,             1,1,32'h0,          1,mem(32'h0),32'h4);
    add(0,0,0,0,0,             1,1,32'h4,          0,mem(32'h0),32'h4);
    add(1,0,0,0,1,             1,1,32'h4,          0,0,0);
    add(0,0,0,0,1,             1,1,32'h0,          1,mem(32'h0),32'h4);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      reset = vecs[i].rst; stall_i = vecs[i].stall; redirect_i = vecs[i].redir;
      redirect_pc_i = vecs[i].rpc; bus.imem_ready_i = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_req", i), bus.imem_req_o, vecs[i].exp_req);
      if (vecs[i].chk_addr) chk($sformatf("v%0d_addr", i), bus.imem_addr_o, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), valid_IF, vecs[i].exp_vld);
      chk($sformatf("v%0d_rd", i), RD_IF, vecs[i].exp_rd);
      chk($sformatf("v%0d_npc", i), nextPC_IF, vecs[i].exp_npc);
    end

    // Random traffic: every presented word must be the next in program order.
    do_reset();
    exp_addr = 32'h0; prev_rd = '0; prev_npc = '0; prev_vld = 1'b0;
    pend = 1'b0; pend_addr = '0; presented = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      st  = ($urandom % 4) == 0;
      rd_ = ($urandom % 20) == 0;
      rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      rdy = ($urandom % 3) != 0;
      stall_i = st; redirect_i = rd_; redirect_pc_i = rpc; bus.imem_ready_i = rdy;
      #1;
      if (pend) begin
        chk("rnd_req_hold", bus.imem_req_o, 1);
        chk("rnd_addr_hold", bus.imem_addr_o, pend_addr);
      end
      pend = bus.imem_req_o & ~rdy;
      pend_addr = bus.imem_addr_o;
      @(posedge clk);
      #1;
      if (rd_) begin
        chk("rnd_redir_valid", valid_IF, 0);
        chk("rnd_redir_rd", RD_IF, 0);
        chk("rnd_redir_npc", nextPC_IF, 0);
        exp_addr = rpc & ~32'h3;
      end else if (st) begin
        chk("rnd_stall_valid", valid_IF, prev_vld);
        chk("rnd_stall_rd", RD_IF, prev_rd);
        chk("rnd_stall_npc", nextPC_IF, prev_npc);
      end else if (valid_IF) begin
        chk("rnd_instr", RD_IF, mem(exp_addr));
        chk("rnd_npc", nextPC_IF, exp_addr + 32'd4);
        exp_addr = exp_addr + 32'd4;
        presented++;
      end else begin
        chk("rnd_bubble_rd", RD_IF, prev_rd);
        chk("rnd_bubble_npc", nextPC_IF, prev_npc);
      end
      prev_vld = valid_IF; prev_rd = RD_IF; prev_npc = nextPC_IF;
    end
    chk("rnd_progress", (presented > 300) ? 32'd1 : 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
